// File: rtl/vga_dither_out_if.sv
// Video bus between the pattern generator and the dithering output stage.
// Carries the 24-bit pixel with its syncs, plus the reduced-width DAC-side result.
interface vga_dither_out_if #(
   parameter int OUT_BITS = 2
);
   logic [23:0]         rgb_in;
   logic                hsync_in;
   logic                vsync_in;
   logic                de_in;
   logic [OUT_BITS-1:0] r_out;
   logic [OUT_BITS-1:0] g_out;
   logic [OUT_BITS-1:0] b_out;
   logic                hsync_out;
   logic                vsync_out;
   logic                de_out;
   logic [1:0]          frame_phase;

   modport master (
      output rgb_in, hsync_in, vsync_in, de_in,
      input  r_out, g_out, b_out, hsync_out, vsync_out, de_out, frame_phase
   );

   modport slave (
      input  rgb_in, hsync_in, vsync_in, de_in,
      output r_out, g_out, b_out, hsync_out, vsync_out, de_out, frame_phase
   );
endinterface

// File: rtl/vga_dither_out.sv
// 4x4 ordered-dither output stage: 8-bit RGB reduced to OUT_BITS per channel, 2-cycle latency.
// Define VGA_DITHER_TEMPORAL_EN to rotate the dither pattern over 4 frames via frame_phase.
module vga_dither_out #(
   parameter int OUT_BITS = 2
) (
   input  logic            clk,
   input  logic            reset,
   vga_dither_out_if.slave vid
);
   localparam int SHIFT = 8 - OUT_BITS;

   logic [23:0]         rgb_s1;
   logic                hsync_s1;
   logic                vsync_s1;
   logic                de_s1;
   logic                vsync_s2;
   logic                de_s2;
   logic [1:0]          col;
   logic [1:0]          row;
   logic [1:0]          phase;
   logic                vsync_rise;
   logic                de_fall;
   logic [3:0]          thr_idx;
   logic [7:0]          thr;
   logic [OUT_BITS-1:0] r_q;
   logic [OUT_BITS-1:0] g_q;
   logic [OUT_BITS-1:0] b_q;
   logic                hsync_q;
   logic                vsync_q;
   logic                de_q;

   function automatic logic [3:0] bayer(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] v;
      v = 4'd0;
      case ({r, c})
         4'h0: v = 4'd0;
         4'h1: v = 4'd8;
         4'h2: v = 4'd2;
         4'h3: v = 4'd10;
         4'h4: v = 4'd12;
         4'h5: v = 4'd4;
         4'h6: v = 4'd14;
         4'h7: v = 4'd6;
         4'h8: v = 4'd3;
         4'h9: v = 4'd11;
         4'hA: v = 4'd1;
         4'hB: v = 4'd9;
         4'hC: v = 4'd15;
         4'hD: v = 4'd7;
         4'hE: v = 4'd13;
         4'hF: v = 4'd5;
         default: v = 4'd0;
      endcase
      return v;
   endfunction

   // Saturating add keeps full-scale input at full-scale output instead of wrapping.
   function automatic logic [OUT_BITS-1:0] quant(input logic [7:0] ch, input logic [7:0] t);
      logic [8:0] sum;
      logic [7:0] sat;
      sum = {1'b0, ch} + {1'b0, t};
      sat = sum[8] ? 8'hFF : sum[7:0];
      return OUT_BITS'(sat >> SHIFT);
   endfunction

   assign vsync_rise = vsync_s1 & ~vsync_s2;
   assign de_fall    = de_s2 & ~de_s1;

   // Threshold is computed wide so that large matrix entries survive the upshift.
   assign thr_idx = bayer(row, col) + {phase, 2'b00};
   assign thr     = 8'(({8'd0, thr_idx} << SHIFT) >> 4);

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_s1   <= '0;
         hsync_s1 <= 1'b0;
         vsync_s1 <= 1'b0;
         de_s1    <= 1'b0;
         vsync_s2 <= 1'b0;
         de_s2    <= 1'b0;
      end else begin
         rgb_s1   <= vid.rgb_in;
         hsync_s1 <= vid.hsync_in;
         vsync_s1 <= vid.vsync_in;
         de_s1    <= vid.de_in;
         vsync_s2 <= vsync_s1;
         de_s2    <= de_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col <= 2'd0;
         row <= 2'd0;
      end else begin
         col <= de_s1 ? col + 2'd1 : 2'd0;
         if (vsync_rise)
            row <= 2'd0;
         else if (de_fall)
            row <= row + 2'd1;
      end
   end

`ifdef VGA_DITHER_TEMPORAL_EN
   always_ff @(posedge clk) begin
      if (reset)
         phase <= 2'd0;
      else if (vsync_rise)
         phase <= phase + 2'd1;
   end
`else
   assign phase = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         de_q    <= 1'b0;
      end else begin
         r_q     <= de_s1 ? quant(rgb_s1[7:0], thr)   : '0;
         g_q     <= de_s1 ? quant(rgb_s1[15:8], thr)  : '0;
         b_q     <= de_s1 ? quant(rgb_s1[23:16], thr) : '0;
         hsync_q <= hsync_s1;
         vsync_q <= vsync_s1;
         de_q    <= de_s1;
      end
   end

   assign vid.r_out       = r_q;
   assign vid.g_out       = g_q;
   assign vid.b_out       = b_q;
   assign vid.hsync_out   = hsync_q;
   assign vid.vsync_out   = vsync_q;
   assign vid.de_out      = de_q;
   assign vid.frame_phase = phase;
endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: scoreboard of expected outputs plus scenario tasks with literal checks.
module tb_vga_dither_out;
   localparam int OUT_BITS = 2;
   localparam int LSB      = 256 >> OUT_BITS;

   typedef struct packed {
      logic [OUT_BITS-1:0] r;
      logic [OUT_BITS-1:0] g;
      logic [OUT_BITS-1:0] b;
      logic                hs;
      logic                vs;
      logic                de;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_dither_out_if #(.OUT_BITS(OUT_BITS)) vid();
   vga_dither_out #(.OUT_BITS(OUT_BITS)) dut (.clk(clk), .reset(reset), .vid(vid));

   exp_t sb_q[$];
   int   cap_r[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   sb_en        = 1'b0;
   int   m_col, m_row, m_phase;
   bit   m_prev_de, m_prev_vs;
   int   bayer_tab [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

   function automatic int model_q(input int ch, input int bp);
      int thr, s;
      thr = (bp * LSB) / 16;
      s = ch + thr;
      if (s > 255) s = 255;
      return s / LSB;
   endfunction

   // Output seen after each edge belongs to the pixel driven two edges earlier.
   always @(negedge clk) begin
      exp_t e;
      if (sb_en && sb_q.size() >= 3) begin
         e = sb_q.pop_front();
         tests_run++;
         if ({vid.r_out, vid.g_out, vid.b_out, vid.hsync_out, vid.vsync_out, vid.de_out} !==
             {e.r, e.g, e.b, e.hs, e.vs, e.de}) begin
            tests_failed++;
            $display("FAIL scoreboard: got r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b, expected r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b",
                     vid.r_out, vid.g_out, vid.b_out, vid.hsync_out, vid.vsync_out, vid.de_out,
                     e.r, e.g, e.b, e.hs, e.vs, e.de);
         end
         if (vid.de_out === 1'b1) cap_r.push_back(int'(vid.r_out));
      end
   end

   task automatic drive(input logic [23:0] rgb, input logic hs, input logic vs, input logic de);
      exp_t e;
      int   bp;
      bp   = (bayer_tab[m_row * 4 + m_col] + 4 * m_phase) % 16;
      e.hs = hs;
      e.vs = vs;
      e.de = de;
      e.r  = de ? OUT_BITS'(model_q(int'(rgb[7:0]), bp))   : '0;
      e.g  = de ? OUT_BITS'(model_q(int'(rgb[15:8]), bp))  : '0;
      e.b  = de ? OUT_BITS'(model_q(int'(rgb[23:16]), bp)) : '0;
      vid.rgb_in   = rgb;
      vid.hsync_in = hs;
      vid.vsync_in = vs;
      vid.de_in    = de;
      sb_q.push_back(e);
      if (de) m_col = (m_col + 1) % 4;
      else    m_col = 0;
      if (vs && !m_prev_vs) begin
         m_row = 0;
`ifdef VGA_DITHER_TEMPORAL_EN
         m_phase = (m_phase + 1) % 4;
`endif
      end else if (!de && m_prev_de) begin
         m_row = (m_row + 1) % 4;
      end
      m_prev_de = de;
      m_prev_vs = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(24'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_vsync();
      repeat (2) drive(24'h0, 1'b0, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic send_line(input bit rnd, input logic [23:0] color, input int active);
      repeat (4) drive(24'h0, 1'b1, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < active; i++)
         drive(rnd ? 24'($urandom) : color, 1'b0, 1'b0, 1'b1);
      idle(2);
   endtask

   task automatic do_reset();
      sb_en = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({vid.r_out, vid.g_out, vid.b_out, vid.hsync_out, vid.vsync_out, vid.de_out, vid.frame_phase} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b ph=%0d, expected all 0",
                  vid.r_out, vid.g_out, vid.b_out, vid.hsync_out, vid.vsync_out, vid.de_out, vid.frame_phase);
      end
      reset = 1'b0;
      sb_q.delete();
      sb_q.push_back('0);
      sb_q.push_back('0);
      m_col = 0; m_row = 0; m_phase = 0;
      m_prev_de = 1'b0; m_prev_vs = 1'b0;
      sb_en = 1'b1;
   endtask

   task automatic start_frame0();
      do_reset();
      repeat (4) send_vsync();
   endtask

   task automatic test_reset();
      vid.rgb_in = 24'h0; vid.hsync_in = 1'b0; vid.vsync_in = 1'b0; vid.de_in = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      idle(4);
   endtask

   task automatic test_black_white();
      int bad;
      start_frame0();
      cap_r.delete();
      repeat (6) send_line(1'b0, 24'h000000, 32);
      idle(3);
      bad = 0;
      foreach (cap_r[i]) if (cap_r[i] != 0) bad++;
      tests_run++;
      if (cap_r.size() != 192 || bad != 0) begin
         tests_failed++;
         $display("FAIL black_frame: got %0d pixels with %0d nonzero, expected 192 with 0", cap_r.size(), bad);
      end
      cap_r.delete();
      repeat (6) send_line(1'b0, 24'hFFFFFF, 32);
      idle(3);
      bad = 0;
      foreach (cap_r[i]) if (cap_r[i] != 3) bad++;
      tests_run++;
      if (cap_r.size() != 192 || bad != 0) begin
         tests_failed++;
         $display("FAIL white_frame: got %0d pixels with %0d not 3, expected 192 with 0", cap_r.size(), bad);
      end
   endtask

   task automatic test_row_tracking();
      int exp_r [20];
      exp_r = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
      start_frame0();
      cap_r.delete();
      repeat (5) send_line(1'b0, 24'h000020, 4);
      idle(3);
      tests_run++;
      if (cap_r.size() != 20) begin
         tests_failed++;
         $display("FAIL row_count: got %0d pixels, expected 20", cap_r.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (cap_r[i] !== exp_r[i]) begin
               tests_failed++;
               $display("FAIL row_pattern[%0d]: got %0d, expected %0d", i, cap_r[i], exp_r[i]);
            end
         end
      end
   endtask

   task automatic test_latency();
      int first_k, width;
      do_reset();
      idle(4);
      drive(24'h0000FF, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (vid.de_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL latency_early: got de_out=%0b after 1 edge, expected 0", vid.de_out);
      end
      drive(24'h0000FF, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (vid.de_out !== 1'b1 || vid.r_out !== 2'd3) begin
         tests_failed++;
         $display("FAIL latency_two: got de_out=%0b r_out=%0d, expected 1 and 3", vid.de_out, vid.r_out);
      end
      idle(4);
      first_k = -1;
      width   = 0;
      for (int k = 0; k < 100; k++) begin
         drive(24'h0, (k < 96) ? 1'b1 : 1'b0, 1'b0, 1'b0);
         if (vid.hsync_out === 1'b1) begin
            if (first_k < 0) first_k = k;
            width++;
         end
      end
      tests_run++;
      if (first_k != 1 || width != 96) begin
         tests_failed++;
         $display("FAIL hsync_pulse: got start=%0d width=%0d, expected start=1 width=96", first_k, width);
      end
   endtask

   task automatic test_temporal();
      int exp0 [4];
      int exp1 [4];
      int ph1;
      exp0 = '{0, 1, 0, 1};
`ifdef VGA_DITHER_TEMPORAL_EN
      exp1 = '{1, 1, 1, 1};
      ph1  = 1;
`else
      exp1 = '{0, 1, 0, 1};
      ph1  = 0;
`endif
      do_reset();
      cap_r.delete();
      send_line(1'b0, 24'h000030, 4);
      idle(3);
      send_vsync();
      tests_run++;
      if (int'(vid.frame_phase) != ph1) begin
         tests_failed++;
         $display("FAIL phase_after_vsync: got %0d, expected %0d", vid.frame_phase, ph1);
      end
      send_line(1'b0, 24'h000030, 4);
      idle(3);
      tests_run++;
      if (cap_r.size() != 8) begin
         tests_failed++;
         $display("FAIL temporal_count: got %0d pixels, expected 8", cap_r.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_r[i] !== exp0[i] || cap_r[i + 4] !== exp1[i]) begin
               tests_failed++;
               $display("FAIL temporal_col%0d: got %0d/%0d, expected %0d/%0d",
                        i, cap_r[i], cap_r[i + 4], exp0[i], exp1[i]);
            end
         end
      end
      repeat (3) send_vsync();
      tests_run++;
      if (vid.frame_phase !== 2'd0) begin
         tests_failed++;
         $display("FAIL phase_wrap: got %0d, expected 0", vid.frame_phase);
      end
   endtask

   task automatic test_reset_midline();
      int exp_r [4];
      exp_r = '{0, 1, 0, 1};
      start_frame0();
      send_line(1'b0, 24'h000020, 4);
      repeat (4) drive(24'h0, 1'b1, 1'b0, 1'b0);
      drive(24'h000020, 1'b0, 1'b0, 1'b1);
      drive(24'h000020, 1'b0, 1'b0, 1'b1);
      do_reset();
      drive(24'h000020, 1'b0, 1'b0, 1'b1);
      drive(24'h000020, 1'b0, 1'b0, 1'b1);
      idle(2);
      send_vsync();
      cap_r.delete();
      send_line(1'b0, 24'h000020, 4);
      idle(3);
      tests_run++;
      if (cap_r.size() != 4) begin
         tests_failed++;
         $display("FAIL midline_count: got %0d pixels, expected 4", cap_r.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_r[i] !== exp_r[i]) begin
               tests_failed++;
               $display("FAIL midline_col%0d: got %0d, expected %0d", i, cap_r[i], exp_r[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      send_vsync();
      repeat (6) send_line(1'b1, 24'h0, 20);
      send_vsync();
      repeat (5) send_line(1'b1, 24'h0, 13);
      idle(3);
   endtask

   initial begin
      test_reset();
      test_black_white();
      test_row_tracking();
      test_latency();
      test_temporal();
      test_reset_midline();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/vga_dither_out.md
Name: vga_dither_out

Overview:
- Output stage directly downstream of the 24-bit RGB pattern generator; feeds the per-channel resistor-ladder DACs.
- Reduces each 8-bit channel to OUT_BITS using 4x4 ordered (Bayer) dithering.
- Pipelines RGB, syncs and display-enable with matched 2-cycle latency.
- Tracks its own column/row/frame phase from de/vsync, so no hpos/vpos input is needed.

Parameters:
- OUT_BITS, 2, output bits per channel; legal range 1..7.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high.
- rgb_in  input  24  {B[23:16], G[15:8], R[7:0]}, 8 bits each.
- hsync_in  input  1  horizontal sync, active-high pulse.
- vsync_in  input  1  vertical sync, active-high pulse.
- de_in  input  1  display enable (active video).
- r_out, g_out, b_out  output  OUT_BITS each  dithered channels.
- hsync_out  output  1  hsync_in delayed 2 cycles.
- vsync_out  output  1  vsync_in delayed 2 cycles.
- de_out  output  1  de_in delayed 2 cycles.
- frame_phase  output  2  current temporal phase (debug).

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0; all pipeline registers, col, row and phase counters 0.
- Reset asserted mid-line: all outputs are 0 on the next edge; after release, the pipeline refills with 2-cycle latency.
- Stage 1 (edge 1):
  - Register rgb_in, hsync_in, vsync_in, de_in into *_s1.
  - Hold de_s2 and vsync_s2, the previous *_s1 values.
- col[1:0]: increments each cycle de_s1=1 (wraps 3->0); cleared when de_s1=0.
- row[1:0]:
  - Increments on the de falling edge (de_s2=1, de_s1=0), wrapping 3->0.
  - Cleared on the vsync rising edge (vsync_s1=1, vsync_s2=0). Clear wins if both events occur in the same cycle.
- phase[1:0]: increments on the vsync rising edge and wraps 3->0. Held at 0 when the optional feature is compiled out.
- Bayer matrix B[row][col]:
  - row0: 0 8 2 10
  - row1: 12 4 14 6
  - row2: 3 11 1 9
  - row3: 15 7 13 5
- b' = (B[row][col] + 4*phase) mod 16.
- thr = (b' << (8-OUT_BITS)) >> 4, in 8-bit arithmetic.
- Per channel: sum = {1'b0, ch} + thr (9 bits). sat = 255 if sum[8], else sum[7:0]. Quantised value = sat[7:8-OUT_BITS].
- Stage 2 (edge 2):
  - r/g/b_out get the quantised values if de_s1=1, else 0.
  - hsync_out, vsync_out, de_out get the *_s1 values.
  - col/row/phase used for a pixel are the values present while that pixel is in stage 1.
- Latency: exactly 2 cycles for every output; syncs, de and colour stay aligned.
- Boundaries:
  - Input 0 always gives 0 (max thr < one LSB step).
  - Input 255 always gives all-ones (saturation).
  - No wrap to 0 on overflow.

Optional Feature:
- Macro: VGA_DITHER_TEMPORAL_EN.
- Defined: phase advances on each vsync rising edge and offsets b' as above, rotating the pattern over 4 frames.
- Undefined: phase is a constant 0, frame_phase=0, b'=B[row][col], no phase logic.

Test Plan:
1. OUT_BITS=2, rgb_in=0x000000 for a full 640x480 frame -> all outputs 0; rgb_in=0xFFFFFF -> all outputs 3 on every active pixel, never wrap to 0.
2. OUT_BITS=2, R=0x20, row 0 after vsync, phase 0 -> r_out sequence 0,1,0,1 over cols 0..3 (sums 32,64,40,72).
3. Latency: de_in rises with R=0xFF at cycle N -> de_out=1 and r_out=3 first seen after edge N+2; hsync_in pulse of 96 cycles -> hsync_out pulse of 96 cycles, delayed 2.
4. Row tracking: R=0x20 over 5 lines -> row0 0,1,0,1; row1 (12,4,14,6) 1,0,1,0; row2 (3,11,1,9) 0,1,0,1; row3 1,0,1,0; row4 repeats row0.
5. Temporal (macro defined): R=0x30, row 0 -> frame 0 gives 0,1,0,1; after one vsync rising edge frame_phase=1 and b'=4,12,6,14 gives 1,1,1,1; after 4 vsyncs frame_phase=0. Macro undefined: frame_phase stays 0, pattern unchanged.
6. Assert reset mid-line for 1 cycle -> next edge all outputs 0; counters restart so the first line after the next vsync uses row 0 and col 0.
